// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational ROM and
// registers the fetched word into IF/ID. An out-of-window fetch freezes the stage.
module fetch_stage #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = 32'h0040_0000,
  parameter int                    MEMORY_DEPTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  branch_taken_i,
  input  logic [15:0]           branch_offset_i,
  input  logic                  jump_i,
  input  logic [25:0]           jump_index_i,
  input  logic                  jump_reg_i,
  input  logic [DATA_WIDTH-1:0] jump_reg_addr_i,
  input  logic [DATA_WIDTH-1:0] instruction_i,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] if_id_instruction_o,
  output logic [DATA_WIDTH-1:0] if_id_pc_plus4_o,
  output logic                  if_id_valid_o,
  output logic                  fetch_fault_o,
  output logic                  dbg_state_o
);

  localparam logic [DATA_WIDTH-1:0] LP_PC_LIMIT = RESET_PC + DATA_WIDTH'(4 * MEMORY_DEPTH);

  typedef enum logic {ST_RUN = 1'b0, ST_FAULT = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_if_id_instruction;
  logic [DATA_WIDTH-1:0] r_if_id_pc_plus4;
  logic                  r_if_id_valid;

  logic [DATA_WIDTH-1:0] w_pc_plus4;
  logic [DATA_WIDTH-1:0] w_branch_target;
  logic [DATA_WIDTH-1:0] w_jump_target;
  logic [DATA_WIDTH-1:0] w_next_pc;
  logic                  w_illegal;
  logic                  w_pc_load;
  logic                  w_ifid_load;
  logic                  w_ifid_bubble;

  // Redirect targets are relative to the instruction currently in ID.
  assign w_pc_plus4      = r_pc + DATA_WIDTH'(4);
  assign w_branch_target = r_if_id_pc_plus4 +
                           {{(DATA_WIDTH-18){branch_offset_i[15]}}, branch_offset_i, 2'b00};
  assign w_jump_target   = {r_if_id_pc_plus4[DATA_WIDTH-1:DATA_WIDTH-4], jump_index_i, 2'b00};

  always_comb begin
    w_next_pc = w_pc_plus4;
    if (jump_reg_i)          w_next_pc = jump_reg_addr_i;
    else if (jump_i)         w_next_pc = w_jump_target;
    else if (branch_taken_i) w_next_pc = w_branch_target;
  end

  assign w_illegal = (r_pc[1:0] != 2'b00) || (r_pc < RESET_PC) || (r_pc >= LP_PC_LIMIT);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_next;
  end

  // Next-state logic: only reset leaves FAULT
  always_comb begin
    w_state_next = r_state;
    if (r_state == ST_RUN && w_illegal) w_state_next = ST_FAULT;
  end

  // Output/control decode; stall outranks flush for the PC but not for IF/ID
  always_comb begin
    w_pc_load     = 1'b0;
    w_ifid_load   = 1'b0;
    w_ifid_bubble = 1'b0;
    if (r_state == ST_RUN) begin
      if (w_illegal) begin
        w_ifid_bubble = 1'b1;
      end else if (stall_i) begin
        w_ifid_bubble = flush_i;
      end else if (flush_i) begin
        w_pc_load     = 1'b1;
        w_ifid_bubble = 1'b1;
      end else begin
        w_pc_load     = 1'b1;
        w_ifid_load   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc                <= RESET_PC;
      r_if_id_instruction <= '0;
      r_if_id_pc_plus4    <= '0;
      r_if_id_valid       <= 1'b0;
    end else begin
      if (w_pc_load) r_pc <= w_next_pc;
      if (w_ifid_bubble) begin
        r_if_id_instruction <= '0;
        r_if_id_pc_plus4    <= '0;
        r_if_id_valid       <= 1'b0;
      end else if (w_ifid_load) begin
        r_if_id_instruction <= instruction_i;
        r_if_id_pc_plus4    <= w_pc_plus4;
        r_if_id_valid       <= 1'b1;
      end
    end
  end

  assign pc_o                = r_pc;
  assign if_id_instruction_o = r_if_id_instruction;
  assign if_id_pc_plus4_o    = r_if_id_pc_plus4;
  assign if_id_valid_o       = r_if_id_valid;
  assign fetch_fault_o       = (r_state == ST_FAULT);
  assign dbg_state_o         = r_state;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage that drives the instruction ROM address and registers its output into the IF/ID pipeline register. It owns the program counter: reset vector, sequential increment, branch/jump/jump-register redirects, stall and flush. It also detects fetches outside the ROM window and reports them as a sticky fault.

## Interface
Parameters:
- DATA_WIDTH, 32, width of PC, instruction and addresses
- RESET_PC, 32'h0040_0000, PC after reset and base of the ROM window
- MEMORY_DEPTH, 64, ROM words; legal window is [RESET_PC, RESET_PC + 4*MEMORY_DEPTH)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- stall_i  in  1  hold PC and IF/ID contents
- flush_i  in  1  load a bubble into IF/ID
- branch_taken_i  in  1  take branch; target from branch_offset_i
- branch_offset_i  in  16  signed word offset (MIPS imm16)
- jump_i  in  1  take jump; target from jump_index_i
- jump_index_i  in  26  MIPS jump index
- jump_reg_i  in  1  take jump-register
- jump_reg_addr_i  in  DATA_WIDTH  jump-register target
- instruction_i  in  DATA_WIDTH  ROM read data (combinational on pc_o)
- pc_o  out  DATA_WIDTH  fetch address to ROM
- if_id_instruction_o  out  DATA_WIDTH  registered instruction
- if_id_pc_plus4_o  out  DATA_WIDTH  registered address of that instruction + 4
- if_id_valid_o  out  1  IF/ID holds a real instruction
- fetch_fault_o  out  1  sticky illegal-fetch flag

## Operation
- Reset values: pc_o = RESET_PC; if_id_instruction_o = 0; if_id_pc_plus4_o = 0; if_id_valid_o = 0; fetch_fault_o = 0.
- pc_plus4 = pc_o + 4, modulo 2^32.
- Redirect targets use if_id_pc_plus4_o, the address after the instruction in ID:
  - branch: if_id_pc_plus4_o + (sign_extend(branch_offset_i) << 2), modulo 2^32
  - jump: {if_id_pc_plus4_o[31:28], jump_index_i, 2'b00}
  - jump-register: jump_reg_addr_i, used unmodified
- next_pc priority: jump_reg_i > jump_i > branch_taken_i > pc_plus4.
- Illegal fetch: pc_o[1:0] != 0, pc_o < RESET_PC, or pc_o >= RESET_PC + 4*MEMORY_DEPTH. Evaluated combinationally on pc_o.
- States: RUN and FAULT.
- RUN, at each clock edge, first match wins:
  1. Illegal fetch: go to FAULT; fetch_fault_o=1; IF/ID takes a bubble; PC holds.
  2. stall_i=1: PC holds; redirect inputs are ignored (the upstream block re-presents them); IF/ID holds, unless flush_i=1, in which case IF/ID takes a bubble.
  3. flush_i=1: PC loads next_pc; IF/ID takes a bubble.
  4. Otherwise: PC loads next_pc; IF/ID loads {instruction_i, pc_plus4, valid=1}.
- Bubble = instruction 0, pc_plus4 0, valid 0.
- FAULT:
  - PC, IF/ID and fetch_fault_o are frozen; if_id_valid_o=0.
  - All inputs are ignored.
  - Only reset exits FAULT.
- A redirect to an illegal target is accepted into PC. The fault is raised at the following edge.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous), regardless of state.

## Timing
- pc_o is registered. The ROM is combinational, so instruction_i is valid in the same cycle as pc_o and is captured at the next edge.
- Fetch latency is 1 cycle: an instruction addressed in cycle N is on if_id_* in cycle N+1.
- Redirect latency: a redirect asserted in cycle N puts the target on pc_o in cycle N+1.
  - The instruction fetched in cycle N (the delay slot) still enters IF/ID unless flush_i is asserted in cycle N.
- After reset release, the first edge captures ROM[RESET_PC] and sets pc_o = RESET_PC+4.
- fetch_fault_o rises exactly one edge after an illegal pc_o appears.

## Test plan
- Reset then 3 free-running edges -> pc_o goes 0x00400000, 0x00400004, 0x00400008, 0x0040000C; if_id_pc_plus4_o = 0x00400008 and if_id_valid_o=1 after edge 2.
- Branch with if_id_pc_plus4_o=0x00400008, branch_offset_i=0xFFFE, branch_taken_i=1 -> next pc_o = 0x00400000. Same with 0x0003 -> next pc_o = 0x00400014.
- jump_i=1, jump_index_i=0x0100004 -> pc_o = 0x00400010. jump_reg_i=1 with 0x00400020 in the same cycle -> pc_o = 0x00400020 (jump-register wins).
- stall_i=1 for 2 cycles -> pc_o and if_id_* unchanged. stall_i=1 and flush_i=1 together -> PC holds, if_id_valid_o=0 and if_id_instruction_o=0. flush_i=1 alone -> PC advances, bubble in IF/ID.
- Fault cases:
  - jump_reg_addr_i=0x00400002 -> pc_o=0x00400002, then fetch_fault_o=1 and if_id_valid_o=0 on the next edge; PC frozen for 5 further cycles under any inputs.
  - Repeat with 0x00400100 (MEMORY_DEPTH=64) -> same response.
- Assert reset while in FAULT and again while stalled -> all outputs at reset values immediately, without waiting for a clock edge; normal fetch from 0x00400000 resumes after release.
